alarm_sequencer: RTL and testbench

- Stateful replacement for the combinational door-alarm decode on the switch board, sitting between the raw SWI switch inputs and the LED/SEG outputs.
- Synchronizes and debounces the door, clock and override switches, then runs a Moore FSM with an entry delay and a latched siren with minimum on-time.
- Drives the siren LED, the armed indicator, a blink output and a 2-bit state code for the display.
- Sign-off condition: the steady-state arming rule is the existing one, armed = interruptor OR NOT relogio, and trigger = porta AND armed.

---
 rtl/alarm_sequencer.sv | 171 +++++++++++++++++
 tb/tb_alarm_sequencer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : alarm_sequencer
// Brief    : Door alarm with input sync/debounce, entry delay, latched siren.
// Revision : 1.0 - initial release
// ============================================================================
module alarm_sequencer #(
  parameter int DEB_CYCLES    = 2,
  parameter int ENTRY_CYCLES  = 4,
  parameter int MIN_ON_CYCLES = 8,
  parameter int BLINK_HALF    = 1
) (
  input  logic       clk_2,
  input  logic       rst_n,
  input  logic       porta,
  input  logic       relogio,
  input  logic       interruptor,
  output logic       sirene,
  output logic       led_armado,
  output logic       led_blink,
  output logic [1:0] estado
);

  localparam int c_DEB_W   = $clog2(DEB_CYCLES + 1);
  localparam int c_TMR_MAX = (ENTRY_CYCLES > MIN_ON_CYCLES) ? ENTRY_CYCLES : MIN_ON_CYCLES;
  localparam int c_TMR_W   = (c_TMR_MAX > 1) ? $clog2(c_TMR_MAX) : 1;
  localparam int c_BLK_W   = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

  localparam logic [c_DEB_W-1:0] c_DEB_LAST   = c_DEB_W'(DEB_CYCLES - 1);
  localparam logic [c_DEB_W-1:0] c_DEB_ONE    = c_DEB_W'(1);
  localparam logic [c_TMR_W-1:0] c_ENTRY_LOAD = c_TMR_W'(ENTRY_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_MINON_LOAD = c_TMR_W'(MIN_ON_CYCLES - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_ONE    = c_TMR_W'(1);
  localparam logic [c_BLK_W-1:0] c_BLK_LAST   = c_BLK_W'(BLINK_HALF - 1);
  localparam logic [c_BLK_W-1:0] c_BLK_ONE    = c_BLK_W'(1);

  localparam logic [1:0] c_ST_IDLE  = 2'd0;
  localparam logic [1:0] c_ST_ARMED = 2'd1;
  localparam logic [1:0] c_ST_ENTRY = 2'd2;
  localparam logic [1:0] c_ST_ALARM = 2'd3;

  // Bit order everywhere: [0] porta, [1] relogio, [2] interruptor
  logic [2:0] w_raw;
  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] w_stable;

  assign w_raw = {interruptor, relogio, porta};

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 3'b000;
      r_sync2 <= 3'b000;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_deb
      logic [c_DEB_W-1:0] r_cnt;
      logic               r_stable;

      always_ff @(posedge clk_2 or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt    <= '0;
          r_stable <= 1'b0;
        end else if (r_sync2[gi] == r_stable) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DEB_LAST) begin
          r_stable <= r_sync2[gi];
          r_cnt    <= '0;
        end else begin
          r_cnt <= r_cnt + c_DEB_ONE;
        end
      end

      assign w_stable[gi] = r_stable;
    end
  endgenerate

  logic w_armed;
  logic w_door;

  assign w_armed = w_stable[2] | ~w_stable[1];
  assign w_door  = w_stable[0];

  logic [1:0]         r_state;
  logic [1:0]         w_state_nx;
  logic [c_TMR_W-1:0] r_tmr;
  logic [c_TMR_W-1:0] w_tmr_nx;

  // One down-counter serves both the entry delay and the siren minimum on-time
  always_comb begin
    w_state_nx = r_state;
    w_tmr_nx   = r_tmr;
    case (r_state)
      c_ST_IDLE: begin
        if (w_armed) w_state_nx = c_ST_ARMED;
      end
      c_ST_ARMED: begin
        if (!w_armed) begin
          w_state_nx = c_ST_IDLE;
        end else if (w_door) begin
          w_state_nx = c_ST_ENTRY;
          w_tmr_nx   = c_ENTRY_LOAD;
        end
      end
      c_ST_ENTRY: begin
        if (!w_armed) begin
          w_state_nx = c_ST_IDLE;
        end else if (r_tmr == '0) begin
          w_state_nx = c_ST_ALARM;
          w_tmr_nx   = c_MINON_LOAD;
        end else begin
          w_tmr_nx = r_tmr - c_TMR_ONE;
        end
      end
      c_ST_ALARM: begin
        if (r_tmr != '0) begin
          w_tmr_nx = r_tmr - c_TMR_ONE;
        end else if (!w_armed) begin
          w_state_nx = c_ST_IDLE;
        end
      end
      default: begin
        w_state_nx = c_ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_tmr   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_tmr   <= w_tmr_nx;
    end
  end

  logic               w_blink_on;
  logic [c_BLK_W-1:0] r_blk_cnt;
  logic               r_blink;

  assign w_blink_on = (r_state == c_ST_ENTRY) || (r_state == c_ST_ALARM);

  always_ff @(posedge clk_2 or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b0;
    end else if (!w_blink_on) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b0;
    end else if (r_blk_cnt == c_BLK_LAST) begin
      r_blk_cnt <= '0;
      r_blink   <= ~r_blink;
    end else begin
      r_blk_cnt <= r_blk_cnt + c_BLK_ONE;
    end
  end

  // Masking keeps the blink dark on the cycle a stale phase survives into IDLE
  assign sirene     = (r_state == c_ST_ALARM);
  assign led_armado = (r_state != c_ST_IDLE);
  assign led_blink  = r_blink & w_blink_on;
  assign estado     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_alarm_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_alarm_sequencer
// Brief    : Directed bench for alarm_sequencer with a per-cycle reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alarm_sequencer;

  localparam int DEB_CYCLES    = 2;
  localparam int ENTRY_CYCLES  = 4;
  localparam int MIN_ON_CYCLES = 8;
  localparam int BLINK_HALF    = 1;

  logic       clk_2 = 1'b0;
  logic       rst_n = 1'b0;
  logic       porta = 1'b0;
  logic       relogio = 1'b1;
  logic       interruptor = 1'b0;
  logic       sirene;
  logic       led_armado;
  logic       led_blink;
  logic [1:0] estado;

  int total = 0;
  int bad   = 0;

  alarm_sequencer #(
    .DEB_CYCLES   (DEB_CYCLES),
    .ENTRY_CYCLES (ENTRY_CYCLES),
    .MIN_ON_CYCLES(MIN_ON_CYCLES),
    .BLINK_HALF   (BLINK_HALF)
  ) u_dut (
    .clk_2      (clk_2),
    .rst_n      (rst_n),
    .porta      (porta),
    .relogio    (relogio),
    .interruptor(interruptor),
    .sirene     (sirene),
    .led_armado (led_armado),
    .led_blink  (led_blink),
    .estado     (estado)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: inputs seen two edges late, debounced by run length,
  // then states tracked by how long they have been occupied.
  bit [2:0] m_d1, m_d2, m_stab;
  int       m_run [3];
  int       m_st, m_dwell, m_bk;

  always @(posedge clk_2 or negedge rst_n) begin : mdl
    bit       armed;
    int       st, nx, dw, bk;
    bit [2:0] raw, d1, d2, stab;
    int       run [3];
    if (!rst_n) begin
      m_d1    <= '0;
      m_d2    <= '0;
      m_stab  <= '0;
      m_run   <= '{0, 0, 0};
      m_st    <= 0;
      m_dwell <= 0;
      m_bk    <= 0;
    end else begin
      raw  = {interruptor, relogio, porta};
      d1   = m_d1;
      d2   = m_d2;
      stab = m_stab;
      run  = m_run;
      st   = m_st;
      dw   = m_dwell;
      bk   = m_bk;
      armed = stab[2] | ~stab[1];
      nx = st;
      if (st >= 2) begin
        dw++;
        bk++;
      end
      case (st)
        0: if (armed) nx = 1;
        1: begin
          if (!armed) nx = 0;
          else if (stab[0]) begin
            nx = 2;
            bk = 0;
          end
        end
        2: begin
          if (!armed) nx = 0;
          else if (dw >= ENTRY_CYCLES) nx = 3;
        end
        default: if (!armed && dw >= MIN_ON_CYCLES) nx = 0;
      endcase
      if (nx != st) dw = 0;
      for (int i = 0; i < 3; i++) begin
        if (d2[i] != stab[i]) begin
          run[i]++;
          if (run[i] >= DEB_CYCLES) begin
            stab[i] = d2[i];
            run[i]  = 0;
          end
        end else begin
          run[i] = 0;
        end
      end
      d2 = d1;
      d1 = raw;
      m_d1    <= d1;
      m_d2    <= d2;
      m_stab  <= stab;
      m_run   <= run;
      m_st    <= nx;
      m_dwell <= dw;
      m_bk    <= bk;
    end
  end

  always @(posedge clk_2) begin
    int exp_blink;
    #1;
    exp_blink = (m_st >= 2) ? ((m_bk / BLINK_HALF) % 2) : 0;
    chk("mdl_estado",     32'(estado),     32'(m_st));
    chk("mdl_sirene",     32'(sirene),     32'(m_st == 3));
    chk("mdl_led_armado", 32'(led_armado), 32'(m_st != 0));
    chk("mdl_led_blink",  32'(led_blink),  32'(exp_blink));
  end

  task automatic steps(input int n);
    repeat (n) begin
      @(posedge clk_2);
      #1;
    end
  endtask

  initial begin
    // 1: reset, release with daytime clock -> brief ARMED then IDLE
    #23;
    chk("rst_estado", 32'(estado), 0);
    chk("rst_sirene", 32'(sirene), 0);
    chk("rst_armado", 32'(led_armado), 0);
    chk("rst_blink",  32'(led_blink), 0);
    @(negedge clk_2);
    rst_n = 1'b1;
    steps(1);
    chk("t1_e1_estado", 32'(estado), 1);
    chk("t1_e1_armado", 32'(led_armado), 1);
    steps(3);
    chk("t1_e4_estado", 32'(estado), 1);
    steps(1);
    chk("t1_e5_estado", 32'(estado), 0);
    steps(20);
    chk("t1_idle_estado", 32'(estado), 0);

    // 2: night -> ARMED on 5th edge
    relogio = 1'b0;
    steps(4);
    chk("t2_e4_estado", 32'(estado), 0);
    steps(1);
    chk("t2_e5_estado", 32'(estado), 1);
    chk("t2_e5_armado", 32'(led_armado), 1);
    chk("t2_e5_sirene", 32'(sirene), 0);

    // 3 + 5: door open, fire after entry delay, disarm during minimum on-time
    porta = 1'b1;
    steps(4);
    chk("t3_e4_estado", 32'(estado), 1);
    steps(1);
    chk("t3_entry_estado", 32'(estado), 2);
    chk("t3_entry_blink", 32'(led_blink), 0);
    steps(1);
    chk("t3_entry1_blink", 32'(led_blink), 1);
    steps(1);
    relogio = 1'b1;
    steps(1);
    chk("t3_entry3_estado", 32'(estado), 2);
    steps(1);
    chk("t3_fire_estado", 32'(estado), 3);
    chk("t3_fire_sirene", 32'(sirene), 1);
    chk("t3_fire_blink", 32'(led_blink), 0);
    steps(7);
    chk("t5_minon_last_sirene", 32'(sirene), 1);
    steps(1);
    chk("t5_exit_estado", 32'(estado), 0);
    chk("t5_exit_sirene", 32'(sirene), 0);

    // 5b: forced armed latches ALARM regardless of door
    interruptor = 1'b1;
    steps(5);
    chk("t5b_armed_estado", 32'(estado), 1);
    steps(1);
    chk("t5b_entry_estado", 32'(estado), 2);
    steps(4);
    chk("t5b_fire_estado", 32'(estado), 3);
    porta = 1'b0;
    steps(50);
    chk("t5b_latched_estado", 32'(estado), 3);
    chk("t5b_latched_sirene", 32'(sirene), 1);
    interruptor = 1'b0;
    steps(4);
    chk("t5b_disarm4_estado", 32'(estado), 3);
    steps(1);
    chk("t5b_disarm5_estado", 32'(estado), 0);

    // 4: disarm inside the entry window cancels before firing
    relogio = 1'b0;
    steps(5);
    chk("t4_armed_estado", 32'(estado), 1);
    porta = 1'b1;
    steps(3);
    relogio = 1'b1;
    steps(2);
    chk("t4_entry_estado", 32'(estado), 2);
    steps(2);
    chk("t4_entry2_estado", 32'(estado), 2);
    steps(1);
    chk("t4_cancel_estado", 32'(estado), 0);
    chk("t4_cancel_blink", 32'(led_blink), 0);
    steps(1);
    chk("t4_nofire_sirene", 32'(sirene), 0);

    // 4b: disarm on the same edge the entry timer expires -> IDLE wins
    relogio = 1'b0;
    steps(5);
    chk("t4b_armed_estado", 32'(estado), 1);
    relogio = 1'b1;
    steps(1);
    chk("t4b_entry_estado", 32'(estado), 2);
    steps(3);
    chk("t4b_entry3_estado", 32'(estado), 2);
    steps(1);
    chk("t4b_tie_estado", 32'(estado), 0);
    chk("t4b_tie_sirene", 32'(sirene), 0);

    // 6: glitch rejection, simultaneous door+disarm, async reset mid-alarm
    porta   = 1'b0;
    relogio = 1'b0;
    steps(5);
    chk("t6_armed_estado", 32'(estado), 1);
    steps(2);
    porta = 1'b1;
    steps(1);
    porta = 1'b0;
    steps(10);
    chk("t6_glitch_estado", 32'(estado), 1);
    porta   = 1'b1;
    relogio = 1'b1;
    steps(4);
    chk("t6_tie4_estado", 32'(estado), 1);
    steps(1);
    chk("t6_tie5_estado", 32'(estado), 0);
    relogio = 1'b0;
    steps(5);
    chk("t6_rearm_estado", 32'(estado), 1);
    steps(5);
    chk("t6_alarm_estado", 32'(estado), 3);
    chk("t6_alarm_sirene", 32'(sirene), 1);
    #3;
    rst_n = 1'b0;
    #1;
    chk("t6_arst_sirene", 32'(sirene), 0);
    chk("t6_arst_estado", 32'(estado), 0);
    chk("t6_arst_armado", 32'(led_armado), 0);
    chk("t6_arst_blink",  32'(led_blink), 0);
    steps(2);
    @(negedge clk_2);
    rst_n = 1'b1;
    steps(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
